// File: rtl/contador_pkg.sv
// Shared definitions for the basic-counter subsystem: default width, count type
// and the prescaler width helper.
package contador_pkg;

    localparam int unsigned COUNT_W_DEFAULT = 8;

    typedef logic [COUNT_W_DEFAULT-1:0] count_t;

    // Bits needed to hold a prescaler phase 0..div-1, never less than one.
    function automatic int unsigned presc_width(input int unsigned div);
        if (div < 32'd2) begin
            return 32'd1;
        end
        return 32'($clog2(div));
    endfunction

endpackage

// File: rtl/contador_prescaler.sv
// Advance-enable generator: tick is high once every DIV clock cycles.
// With DIV=1 it collapses to a constant enable.
module contador_prescaler
    import contador_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned PW = presc_width(DIV);

    generate
        if (DIV <= 32'd1) begin : g_bypass
            logic unused_ok;
            assign unused_ok = clk ^ reset;
            assign tick      = 1'b1;
        end else begin : g_div
            localparam logic [PW-1:0] LAST = PW'(DIV - 32'd1);

            logic [PW-1:0] phase_q;
            logic [PW-1:0] phase_d;

            always_comb begin
                phase_d = phase_q + PW'(1);
                if (phase_q == LAST) begin
                    phase_d = '0;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_d;
                end
            end

            assign tick = (phase_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/contador_4bits.sv
// Free-running up-counter with terminal-count wrap and optional prescaled advance.
// wrap is decoded from registered state and is forced low while reset is held.
module contador_4bits
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH       = COUNT_W_DEFAULT,
    parameter int unsigned MAX_COUNT   = (2 ** WIDTH) - 1,
    parameter int unsigned RESET_VALUE = 0,
    parameter int unsigned DIV         = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

    // Reject illegal parameter combinations at elaboration.
    generate
        if (WIDTH < 32'd1 || WIDTH > 32'd32) begin : g_bad_width
            $error("contador_4bits: WIDTH must be in 1..32");
        end
        if ((MAX_COUNT >> WIDTH) != 32'd0) begin : g_bad_max
            $error("contador_4bits: MAX_COUNT must be < 2**WIDTH");
        end
        if (RESET_VALUE > MAX_COUNT) begin : g_bad_rst
            $error("contador_4bits: RESET_VALUE must be <= MAX_COUNT");
        end
        if (DIV < 32'd1) begin : g_bad_div
            $error("contador_4bits: DIV must be >= 1");
        end
    endgenerate

    logic             tick;
    logic             at_max;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    contador_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign at_max = (count_q == MAX_V);

    always_comb begin
        count_d = count_q;
        if (tick) begin
            count_d = at_max ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RST_V;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign wrap  = reset & tick & at_max;

endmodule

// File: tb/tb_contador_4bits.sv
// Bench for contador_4bits: four builds (default, MAX_COUNT=9, DIV=4, RESET_VALUE=200)
// run side by side against a behavioural model feeding a scoreboard queue.
`timescale 1ns/1ps
module tb_contador_4bits;

    typedef struct packed {
        logic [3:0][7:0] cnt;
        logic [3:0]      wr;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [7:0] c0, c1, c2, c3;
    logic       w0, w1, w2, w3;

    exp_t sb[$];
    exp_t cur;
    int   m_cnt[4];
    int   m_pre[4];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    contador_4bits u_def (.clk(clk), .reset(reset), .count(c0), .wrap(w0));
    contador_4bits #(.MAX_COUNT(9)) u_m9 (.clk(clk), .reset(reset), .count(c1), .wrap(w1));
    contador_4bits #(.DIV(4)) u_d4 (.clk(clk), .reset(reset), .count(c2), .wrap(w2));
    contador_4bits #(.RESET_VALUE(200)) u_rv (.clk(clk), .reset(reset), .count(c3), .wrap(w3));

    function automatic int max_of(input int d);
        return (d == 1) ? 9 : 255;
    endfunction

    function automatic int div_of(input int d);
        return (d == 2) ? 4 : 1;
    endfunction

    function automatic int rv_of(input int d);
        return (d == 3) ? 200 : 0;
    endfunction

    function automatic logic [7:0] act_cnt(input int d);
        case (d)
            0:       return c0;
            1:       return c1;
            2:       return c2;
            default: return c3;
        endcase
    endfunction

    function automatic logic act_wr(input int d);
        case (d)
            0:       return w0;
            1:       return w1;
            2:       return w2;
            default: return w3;
        endcase
    endfunction

    function automatic bit model_tick(input int d);
        return (div_of(d) == 1) || (m_pre[d] == div_of(d) - 1);
    endfunction

    // Expected outputs for the model's current state.
    function automatic exp_t model_out();
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            e.cnt[d] = 8'(m_cnt[d]);
            e.wr[d]  = reset && model_tick(d) && (m_cnt[d] == max_of(d));
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            m_cnt[d] = rv_of(d);
            m_pre[d] = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 4; d++) begin
            if (!reset) begin
                m_cnt[d] = rv_of(d);
                m_pre[d] = 0;
            end else begin
                if (model_tick(d)) begin
                    m_cnt[d] = (m_cnt[d] == max_of(d)) ? 0 : m_cnt[d] + 1;
                end
                m_pre[d] = (m_pre[d] + 1) % div_of(d);
            end
        end
    endtask

    // One clock: push the post-edge expectation, then pop it once the DUT has settled.
    task automatic cycle();
        model_edge();
        sb.push_back(model_out());
        @(posedge clk);
        @(negedge clk);
        cyc++;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: size=0 required=1");
        end else begin
            cur = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        model_reset();
        cur = model_out();
        #1;
        for (int d = 0; d < 4; d++) begin
            total++;
            if (act_cnt(d) !== cur.cnt[d] || act_wr(d) !== 1'b0) begin
                bad++;
                $display("FAIL reset_async: dut%0d count=%0d wrap=%b required count=%0d wrap=0",
                         d, act_cnt(d), act_wr(d), cur.cnt[d]);
            end
        end
        @(negedge clk);
        cycle();
        for (int d = 0; d < 4; d++) begin
            if (act_cnt(d) !== cur.cnt[d] || act_wr(d) !== cur.wr[d]) begin
                bad++;
                $display("FAIL reset_hold: dut%0d count=%0d wrap=%b required count=%0d wrap=%b",
                         d, act_cnt(d), act_wr(d), cur.cnt[d], cur.wr[d]);
            end
        end
        reset = 1'b1;
        cyc = 0;
        #1;
        total++;
        if (c0 !== 8'd0 || c3 !== 8'd200) begin
            bad++;
            $display("FAIL reset_release: count0=%0d count3=%0d required 0 and 200", c0, c3);
        end
    endtask

    task automatic test_reset_value();
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (c3 !== cur.cnt[3] || w3 !== cur.wr[3]) begin
                bad++;
                $display("FAIL reset_value_seq: cyc=%0d count=%0d wrap=%b required count=%0d wrap=%b",
                         cyc, c3, w3, cur.cnt[3], cur.wr[3]);
            end
        end
    endtask

    task automatic test_count_default();
        while (cyc < 262) begin
            cycle();
            if (c0 !== cur.cnt[0] || w0 !== cur.wr[0]) begin
                bad++;
                $display("FAIL default_seq: cyc=%0d count=%0d wrap=%b required count=%0d wrap=%b",
                         cyc, c0, w0, cur.cnt[0], cur.wr[0]);
            end
        end
    endtask

    task automatic test_max9();
        for (int i = 0; i < 25; i++) begin
            cycle();
            if (c1 !== cur.cnt[1] || w1 !== cur.wr[1]) begin
                bad++;
                $display("FAIL max9_seq: cyc=%0d count=%0d wrap=%b required count=%0d wrap=%b",
                         cyc, c1, w1, cur.cnt[1], cur.wr[1]);
            end
        end
    endtask

    task automatic test_div4();
        for (int i = 0; i < 1030; i++) begin
            cycle();
            if (c2 !== cur.cnt[2] || w2 !== cur.wr[2]) begin
                bad++;
                $display("FAIL div4_seq: cyc=%0d count=%0d wrap=%b required count=%0d wrap=%b",
                         cyc, c2, w2, cur.cnt[2], cur.wr[2]);
            end
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        while (cur.cnt[0] != 8'd37 && guard < 300) begin
            cycle();
            guard++;
        end
        total++;
        if (c0 !== 8'd37) begin
            bad++;
            $display("FAIL midcount_reach: count=%0d required=37", c0);
        end
        #2 reset = 1'b0;
        model_reset();
        cur = model_out();
        #1;
        for (int d = 0; d < 4; d++) begin
            total++;
            if (act_cnt(d) !== cur.cnt[d] || act_wr(d) !== 1'b0) begin
                bad++;
                $display("FAIL midcount_reset: dut%0d count=%0d wrap=%b required count=%0d wrap=0",
                         d, act_cnt(d), act_wr(d), cur.cnt[d]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            for (int d = 0; d < 4; d++) begin
                if (act_cnt(d) !== cur.cnt[d] || act_wr(d) !== cur.wr[d]) begin
                    bad++;
                    $display("FAIL resume: cyc=%0d dut%0d count=%0d wrap=%b required count=%0d wrap=%b",
                             i, d, act_cnt(d), act_wr(d), cur.cnt[d], cur.wr[d]);
                end
            end
        end
        total++;
        if (c2 !== 8'd2) begin
            bad++;
            $display("FAIL resume_div4_phase: count=%0d required=2", c2);
        end
    endtask

    initial begin
        test_reset();
        test_reset_value();
        test_count_default();
        test_max9();
        test_div4();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
